// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential double-dabble binary-to-BCD converter, one input bit per clock.
// Start/busy/done handshake; BCD output is registered and holds the last result.
module bin_to_bcd_seq #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   BCD
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t                    state_q, state_d;
    logic [WIDTH-1:0]          shift_q, shift_d;
    logic [4*DIGITS-1:0]       dig_q, dig_d, bcd_q, bcd_d, adj;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [4*DIGITS+WIDTH-1:0] sh;
    for (genvar i = 0; i < DIGITS; i++) begin : g_adj
        assign adj[4*i+:4] = (dig_q[4*i+:4] >= 4'd5) ? dig_q[4*i+:4] + 4'd3 : dig_q[4*i+:4];
    end
    // adjusted digits and shift register move left together as one word
    assign sh = {adj, shift_q} << 1;
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        dig_d   = dig_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        case (state_q)
            SHIFT: begin
                shift_d = sh[WIDTH-1:0];
                dig_d   = sh[4*DIGITS+WIDTH-1:WIDTH];
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    bcd_d   = sh[4*DIGITS+WIDTH-1:WIDTH];
                    state_d = DONE;
                end
            end
            default: begin
                if (start) begin
                    shift_d = bin;
                    dig_d   = '0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            dig_q   <= '0;
            cnt_q   <= '0;
            bcd_q   <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            dig_q   <= dig_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
        end
    end
    assign busy = (state_q == SHIFT);
    assign done = (state_q == DONE);
    assign BCD  = bcd_q;
endmodule
